if_id_stage: RTL and testbench

IF/ID pipeline stage with integrated load-use hazard control. It sits between instruction fetch and decode, directly upstream of the ID/EX register. It captures the fetched PC/instruction pair, holds it for one cycle on a load-use hazard against the instruction in EX, and squashes it on a taken branch/jump resolved in EX. It also drives the PC enable and the ID/EX bubble request, and keeps saturating stall/flush performance counters.

---
 rtl/pipe_pkg.sv | 29 ++
 rtl/hazard_detect.sv | 28 ++
 rtl/if_id_stage.sv | 101 ++++++++++
 tb/tb_if_id_stage.sv | 185 ++++++++++++++++++
 4 files changed

// File: rtl/pipe_pkg.sv
// Shared opcode constants, NOP encoding and register-use helpers for the pipeline.
package pipe_pkg;

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;

    // addi x0, x0, 0
    localparam logic [31:0] NOP = 32'h0000_0013;

    // Everything except the upper-immediate forms and JAL reads rs1.
    function automatic logic uses_rs1(input logic [31:0] inst);
        logic [6:0] op;
        op = inst[6:0];
        return !(op == OP_LUI || op == OP_AUIPC || op == OP_JAL);
    endfunction

    // Only register-register, store and branch forms read rs2.
    function automatic logic uses_rs2(input logic [31:0] inst);
        logic [6:0] op;
        op = inst[6:0];
        return (op == OP_R || op == OP_STORE || op == OP_BRANCH);
    endfunction

endpackage

// File: rtl/hazard_detect.sv
// Load-use hazard detection between the instruction in ID and a load in EX.
module hazard_detect
    import pipe_pkg::*;
(
    input  logic [31:0] inst_ID,
    input  logic        valid_ID,
    input  logic [31:0] inst_EX,
    input  logic        RegWEn_EX,
    output logic        lu
);

    logic [4:0] rd_EX;
    logic [4:0] rs1_ID;
    logic [4:0] rs2_ID;
    logic       src_match;

    // A load in EX whose destination feeds a source the ID instruction actually reads.
    always_comb begin
        rd_EX     = inst_EX[11:7];
        rs1_ID    = inst_ID[19:15];
        rs2_ID    = inst_ID[24:20];
        src_match = (uses_rs1(inst_ID) && (rd_EX == rs1_ID)) ||
                    (uses_rs2(inst_ID) && (rd_EX == rs2_ID));
        lu        = valid_ID && (inst_EX[6:0] == OP_LOAD) && RegWEn_EX &&
                    (rd_EX != 5'd0) && src_match;
    end

endmodule

// File: rtl/if_id_stage.sv
// IF/ID pipeline register with load-use stall, branch flush and perf counters.
module if_id_stage
    import pipe_pkg::*;
#(
    parameter int Width    = 32,
    parameter int CntWidth = 16
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic [Width-1:0]    pc_IF,
    input  logic [Width-1:0]    inst_IF,
    input  logic                fetch_valid_IF,
    input  logic                PCSel_EX,
    input  logic [Width-1:0]    inst_EX,
    input  logic                RegWEn_EX,
    output logic [Width-1:0]    pc_ID,
    output logic [Width-1:0]    inst_ID,
    output logic                valid_ID,
    output logic                pc_en_o,
    output logic                bubble_EX_o,
    output logic [CntWidth-1:0] stall_cnt_o,
    output logic [CntWidth-1:0] flush_cnt_o
);

    localparam logic [Width-1:0]    NOP_W   = Width'(NOP);
    localparam logic [CntWidth-1:0] CNT_MAX = '1;

    logic [Width-1:0]    pc_d, pc_q;
    logic [Width-1:0]    inst_d, inst_q;
    logic                valid_d, valid_q;
    logic [CntWidth-1:0] stall_cnt_d, stall_cnt_q;
    logic [CntWidth-1:0] flush_cnt_d, flush_cnt_q;
    logic                lu;

    hazard_detect u_hazard_detect (
        .inst_ID   (inst_q[31:0]),
        .valid_ID  (valid_q),
        .inst_EX   (inst_EX[31:0]),
        .RegWEn_EX (RegWEn_EX),
        .lu        (lu)
    );

    // Next-state selection: flush beats load-use, which beats a fetch bubble.
    always_comb begin
        pc_d        = pc_q;
        inst_d      = inst_q;
        valid_d     = valid_q;
        stall_cnt_d = stall_cnt_q;
        flush_cnt_d = flush_cnt_q;
        if (PCSel_EX) begin
            pc_d    = pc_IF;
            inst_d  = NOP_W;
            valid_d = 1'b0;
            if (flush_cnt_q != CNT_MAX) flush_cnt_d = flush_cnt_q + 1'b1;
        end else if (lu) begin
            if (stall_cnt_q != CNT_MAX) stall_cnt_d = stall_cnt_q + 1'b1;
        end else if (!fetch_valid_IF) begin
            pc_d    = pc_IF;
            inst_d  = NOP_W;
            valid_d = 1'b0;
        end else begin
            pc_d    = pc_IF;
            inst_d  = inst_IF;
            valid_d = 1'b1;
        end
    end

    // PC enable and ID/EX bubble request, same-cycle; reset holds PC and bubbles EX.
    always_comb begin
        pc_en_o     = 1'b0;
        bubble_EX_o = 1'b1;
        if (!rst_i) begin
            pc_en_o     = PCSel_EX || (!lu && fetch_valid_IF);
            bubble_EX_o = PCSel_EX || lu;
        end
    end

    // Stage register and counters with synchronous reset.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            pc_q        <= '0;
            inst_q      <= NOP_W;
            valid_q     <= 1'b0;
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            pc_q        <= pc_d;
            inst_q      <= inst_d;
            valid_q     <= valid_d;
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    assign pc_ID       = pc_q;
    assign inst_ID     = inst_q;
    assign valid_ID    = valid_q;
    assign stall_cnt_o = stall_cnt_q;
    assign flush_cnt_o = flush_cnt_q;

endmodule

// File: tb/tb_if_id_stage.sv
// Directed bench for if_id_stage with 4-bit counters to reach saturation quickly.
module tb_if_id_stage;

    localparam logic [31:0] NOP_I   = 32'h0000_0013;
    localparam logic [31:0] LW_X5   = 32'h0000_A283; // lw x5,0(x1)
    localparam logic [31:0] LW_X0   = 32'h0000_A003; // lw x0,0(x1)
    localparam logic [31:0] ADD_X5  = 32'h0022_8333; // add x6,x5,x2
    localparam logic [31:0] ADD_X0  = 32'h0020_0333; // add x6,x0,x2
    localparam logic [31:0] LUI_1   = 32'h0000_12B7; // lui x5,1
    localparam logic [31:0] LUI_28  = 32'h0002_82B7; // lui x5,0x28 (rs1 field = 5)
    localparam logic [31:0] SW_X5   = 32'h0051_2023; // sw x5,0(x2)

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic [31:0] pc_IF, inst_IF, inst_EX;
    logic        fetch_valid_IF, PCSel_EX, RegWEn_EX;
    logic [31:0] pc_ID, inst_ID;
    logic        valid_ID, pc_en_o, bubble_EX_o;
    logic [3:0]  stall_cnt_o, flush_cnt_o;

    int total = 0;
    int bad   = 0;
    logic [3:0] exp_stall;

    always #5 clk_i = ~clk_i;

    if_id_stage #(.Width(32), .CntWidth(4)) dut (
        .clk_i          (clk_i),
        .rst_i          (rst_i),
        .pc_IF          (pc_IF),
        .inst_IF        (inst_IF),
        .fetch_valid_IF (fetch_valid_IF),
        .PCSel_EX       (PCSel_EX),
        .inst_EX        (inst_EX),
        .RegWEn_EX      (RegWEn_EX),
        .pc_ID          (pc_ID),
        .inst_ID        (inst_ID),
        .valid_ID       (valid_ID),
        .pc_en_o        (pc_en_o),
        .bubble_EX_o    (bubble_EX_o),
        .stall_cnt_o    (stall_cnt_o),
        .flush_cnt_o    (flush_cnt_o)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    task automatic chk_id(input string tag, input logic [31:0] pc, input logic [31:0] inst,
                          input logic v);
        chk({tag, ".pc"}, pc_ID, pc);
        chk({tag, ".inst"}, inst_ID, inst);
        chk({tag, ".valid"}, {31'd0, valid_ID}, {31'd0, v});
    endtask

    task automatic chk_ctl(input string tag, input logic pe, input logic bb);
        chk({tag, ".pc_en"}, {31'd0, pc_en_o}, {31'd0, pe});
        chk({tag, ".bubble"}, {31'd0, bubble_EX_o}, {31'd0, bb});
    endtask

    initial begin
        rst_i = 1'b1; pc_IF = 32'h100; inst_IF = ADD_X5; fetch_valid_IF = 1'b1;
        PCSel_EX = 1'b0; inst_EX = NOP_I; RegWEn_EX = 1'b0;
        step(); step();

        // reset values
        chk_id("rst", 32'h0, NOP_I, 1'b0);
        chk("rst.stall", {28'd0, stall_cnt_o}, 32'd0);
        chk("rst.flush", {28'd0, flush_cnt_o}, 32'd0);
        chk_ctl("rst", 1'b0, 1'b1);

        // first normal edge
        rst_i = 1'b0;
        #1 chk_ctl("norm0", 1'b1, 1'b0);
        step();
        chk_id("norm0", 32'h100, ADD_X5, 1'b1);

        // load-use on rs1: one stall cycle, ID holds
        inst_EX = LW_X5; RegWEn_EX = 1'b1; pc_IF = 32'h104; inst_IF = SW_X5;
        #1 chk_ctl("lu1", 1'b0, 1'b1);
        step();
        chk_id("lu1.hold", 32'h100, ADD_X5, 1'b1);
        chk("lu1.stall", {28'd0, stall_cnt_o}, 32'd1);
        // ID/EX now holds the bubble: the held instruction advances
        inst_EX = NOP_I; RegWEn_EX = 1'b0;
        #1 chk_ctl("lu1.rel", 1'b1, 1'b0);
        step();
        chk_id("lu1.adv", 32'h104, SW_X5, 1'b1);

        // load-use through rs2 of a store
        inst_EX = LW_X5; RegWEn_EX = 1'b1; pc_IF = 32'h108; inst_IF = LUI_1;
        #1 chk_ctl("lu_rs2", 1'b0, 1'b1);
        step();
        chk("lu_rs2.stall", {28'd0, stall_cnt_o}, 32'd2);
        chk_id("lu_rs2.hold", 32'h104, SW_X5, 1'b1);
        inst_EX = NOP_I; RegWEn_EX = 1'b0;
        step();
        chk_id("lui.in", 32'h108, LUI_1, 1'b1);

        // no false hazard: LUI does not read rs1
        inst_EX = LW_X5; RegWEn_EX = 1'b1; pc_IF = 32'h10C; inst_IF = LUI_28;
        #1 chk_ctl("nolu.lui", 1'b1, 1'b0);
        step();
        chk_id("lui28.in", 32'h10C, LUI_28, 1'b1);
        #1 chk_ctl("nolu.lui28", 1'b1, 1'b0);
        chk("nolu.stall", {28'd0, stall_cnt_o}, 32'd2);

        // no false hazard: load destination x0
        inst_EX = NOP_I; RegWEn_EX = 1'b0; pc_IF = 32'h110; inst_IF = ADD_X0;
        step();
        inst_EX = LW_X0; RegWEn_EX = 1'b1;
        #1 chk_ctl("nolu.x0", 1'b1, 1'b0);
        // no hazard when the load does not write
        inst_EX = LW_X5; RegWEn_EX = 1'b0; inst_IF = ADD_X5; pc_IF = 32'h114;
        step();
        chk_id("add.in", 32'h114, ADD_X5, 1'b1);
        #1 chk_ctl("nolu.nowen", 1'b1, 1'b0);
        chk("nolu2.stall", {28'd0, stall_cnt_o}, 32'd2);

        // flush concurrent with a load-use stall
        RegWEn_EX = 1'b1; PCSel_EX = 1'b1; pc_IF = 32'h200; inst_IF = SW_X5;
        #1 chk_ctl("flush", 1'b1, 1'b1);
        step();
        chk_id("flush", 32'h200, NOP_I, 1'b0);
        chk("flush.cnt", {28'd0, flush_cnt_o}, 32'd1);
        chk("flush.stall", {28'd0, stall_cnt_o}, 32'd2);
        PCSel_EX = 1'b0; inst_EX = NOP_I; RegWEn_EX = 1'b0;
        pc_IF = 32'h200; inst_IF = ADD_X5;
        step();
        chk_id("target", 32'h200, ADD_X5, 1'b1);

        // fetch bubbles
        fetch_valid_IF = 1'b0;
        for (int i = 0; i < 3; i++) begin
            pc_IF = 32'h204 + 32'(i);
            #1 chk_ctl($sformatf("fb%0d", i), 1'b0, 1'b0);
            step();
            chk_id($sformatf("fb%0d", i), 32'h204 + 32'(i), NOP_I, 1'b0);
        end
        chk("fb.stall", {28'd0, stall_cnt_o}, 32'd2);
        chk("fb.flush", {28'd0, flush_cnt_o}, 32'd1);

        // stall counter saturation
        fetch_valid_IF = 1'b1; pc_IF = 32'h300; inst_IF = ADD_X5;
        step();
        inst_EX = LW_X5; RegWEn_EX = 1'b1;
        exp_stall = 4'd2;
        for (int i = 0; i < 20; i++) begin
            step();
            if (exp_stall != 4'hF) exp_stall = exp_stall + 4'd1;
        end
        chk("sat.stall", {28'd0, stall_cnt_o}, {28'd0, exp_stall});
        chk("sat.stall_f", {28'd0, stall_cnt_o}, 32'hF);
        chk_id("sat.hold", 32'h300, ADD_X5, 1'b1);

        // flush counter saturation (1 earlier + 20 -> 15)
        PCSel_EX = 1'b1;
        for (int i = 0; i < 20; i++) step();
        chk("sat.flush", {28'd0, flush_cnt_o}, 32'hF);
        chk("sat.flush_stall", {28'd0, stall_cnt_o}, 32'hF);

        // reset during a stall wins
        PCSel_EX = 1'b0; inst_EX = NOP_I; RegWEn_EX = 1'b0; inst_IF = ADD_X5; pc_IF = 32'h400;
        step();
        inst_EX = LW_X5; RegWEn_EX = 1'b1; rst_i = 1'b1;
        #1 chk_ctl("rst2", 1'b0, 1'b1);
        step();
        chk_id("rst2", 32'h0, NOP_I, 1'b0);
        chk("rst2.stall", {28'd0, stall_cnt_o}, 32'd0);
        chk("rst2.flush", {28'd0, flush_cnt_o}, 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
